cfg_mux_bank: RTL and testbench

- Parametrised successor to the fixed 4:1 and 16:1 config-driven routing muxes: a bank of N_CHAN independent N_INPUTS:1 muxes.
- Selects come from a double-buffered configuration store instead of free-running latches.
- Select bits are loaded serially over a valid/ready handshake into a shadow register, then committed atomically to the active register, so routing never passes through partially loaded states.
- Sits between the fabric configuration controller and the tile routing.

---
 rtl/cfg_mux_bank.sv | 117 +++++++++++
 tb/tb_cfg_mux_bank.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/cfg_mux_bank.sv
// Bank of N_CHAN independent N_INPUTS:1 routing muxes. Selects come from a
// double-buffered store: serial shadow load, then atomic commit into the active register.
module cfg_mux_bank #(
  parameter  int unsigned N_INPUTS = 16,
  parameter  int unsigned N_CHAN   = 4,
  localparam int unsigned SEL_W    = $clog2(N_INPUTS),
  localparam int unsigned TOTAL    = N_CHAN * SEL_W
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic                         cfg_bit,
  input  logic                         cfg_commit,
  input  logic                         cfg_abort,
  input  logic                         cfg_err_clr,
  input  logic [N_CHAN*N_INPUTS-1:0]   IN,
  output logic [N_CHAN-1:0]            O,
  output logic [TOTAL-1:0]             active_sel,
  output logic                         cfg_full,
  output logic                         commit_done,
  output logic                         cfg_err
);

  localparam int unsigned CNT_W = $clog2(TOTAL + 1);

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_LOADING = 2'd1,
    S_FULL    = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [TOTAL-1:0]   shadow_q, shadow_d;
  logic [TOTAL-1:0]   active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               full_q, full_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               err_set;
  logic               xfer;

  // Next-state: abort beats commit and transfer; commit only succeeds from FULL.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    err_set  = 1'b0;
    xfer     = cfg_valid && ready_q;

    if (cfg_abort) begin
      shadow_d = '0;
      cnt_d    = '0;
      state_d  = S_EMPTY;
    end else if (state_q == S_FULL) begin
      if (cfg_commit) begin
        active_d = shadow_q;
        shadow_d = '0;
        cnt_d    = '0;
        state_d  = S_EMPTY;
        done_d   = 1'b1;
      end
    end else begin
      err_set = cfg_commit;
      if (xfer) begin
        shadow_d = {cfg_bit, shadow_q[TOTAL-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        state_d  = (cnt_q == CNT_W'(TOTAL - 1)) ? S_FULL : S_LOADING;
      end
    end

    err_d   = err_set | (err_q & ~cfg_err_clr);
    ready_d = (state_d != S_FULL);
    full_d  = (state_d == S_FULL);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_EMPTY;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      full_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Routing is combinational from the active register only.
  for (genvar c = 0; c < int'(N_CHAN); c++) begin : g_chan
    logic [N_INPUTS-1:0] in_ch;
    logic [SEL_W-1:0]    sel_ch;
    assign in_ch  = IN[c*N_INPUTS +: N_INPUTS];
    assign sel_ch = active_q[c*SEL_W +: SEL_W];
    assign O[c]   = in_ch[sel_ch];
  end

  assign cfg_ready   = ready_q;
  assign cfg_full    = full_q;
  assign commit_done = done_q;
  assign cfg_err     = err_q;
  assign active_sel  = active_q;

endmodule

// File: tb/tb_cfg_mux_bank.sv
// Scoreboard bench for cfg_mux_bank: a behavioural model queues the expected
// post-edge status for every driven cycle, which is popped and compared one edge later.
module tb_cfg_mux_bank;

  localparam int unsigned NI = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned TW = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          cfg_valid = 1'b0, cfg_bit = 1'b0, cfg_commit = 1'b0;
  logic          cfg_abort = 1'b0, cfg_err_clr = 1'b0;
  logic [NC*NI-1:0] IN = '0;
  logic          cfg_ready, cfg_full, commit_done, cfg_err;
  logic [NC-1:0] O;
  logic [TW-1:0] active_sel;

  cfg_mux_bank #(.N_INPUTS(NI), .N_CHAN(NC)) dut (
    .CLK(CLK), .RST(RST), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_bit(cfg_bit), .cfg_commit(cfg_commit), .cfg_abort(cfg_abort),
    .cfg_err_clr(cfg_err_clr), .IN(IN), .O(O), .active_sel(active_sel),
    .cfg_full(cfg_full), .commit_done(commit_done), .cfg_err(cfg_err)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          ready;
    logic          full;
    logic          done;
    logic          err;
    logic [TW-1:0] act;
  } exp_t;

  exp_t exp_q[$];

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state
  logic [TW-1:0] m_sh  = '0;
  logic [TW-1:0] m_act = '0;
  int            m_cnt = 0;
  logic          m_err = 1'b0;
  logic          m_done = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NC-1:0] ref_mux(input logic [NC*NI-1:0] din, input logic [TW-1:0] act);
    logic [NC-1:0] r;
    for (int c = 0; c < NC; c++) r[c] = din[c*NI + int'(act[c*4 +: 4])];
    return r;
  endfunction

  // Drive one cycle, advance the model, and check the DUT after the edge.
  task automatic step(input logic rst, input logic v, input logic b,
                      input logic cm, input logic ab, input logic clr);
    exp_t e;
    exp_t g;
    logic full_now;
    full_now = (m_cnt == TW);
    if (rst) begin
      m_sh = '0; m_act = '0; m_cnt = 0; m_err = 1'b0; m_done = 1'b0;
    end else if (ab) begin
      m_sh = '0; m_cnt = 0; m_done = 1'b0;
      if (clr) m_err = 1'b0;
    end else if (full_now) begin
      m_done = cm;
      if (cm) begin
        m_act = m_sh; m_sh = '0; m_cnt = 0;
      end
      if (clr) m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      if (v) begin
        m_sh = {b, m_sh[TW-1:1]};
        m_cnt++;
      end
      if (cm) m_err = 1'b1;
      else if (clr) m_err = 1'b0;
    end
    e.ready = (m_cnt != TW);
    e.full  = (m_cnt == TW);
    e.done  = m_done;
    e.err   = m_err;
    e.act   = m_act;
    exp_q.push_back(e);

    RST = rst; cfg_valid = v; cfg_bit = b; cfg_commit = cm;
    cfg_abort = ab; cfg_err_clr = clr;
    @(posedge CLK);
    #1;
    RST = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0; cfg_commit = 1'b0;
    cfg_abort = 1'b0; cfg_err_clr = 1'b0;

    g = exp_q.pop_front();
    check_val("ready",  64'(cfg_ready),   64'(g.ready));
    check_val("full",   64'(cfg_full),    64'(g.full));
    check_val("done",   64'(commit_done), 64'(g.done));
    check_val("err",    64'(cfg_err),     64'(g.err));
    check_val("active", 64'(active_sel),  64'(g.act));
    check_val("route",  64'(O),           64'(ref_mux(IN, g.act)));
  endtask

  task automatic load_bits(input logic [TW-1:0] val, input int n, input int first);
    for (int i = first; i < first + n; i++) step(1'b0, 1'b1, val[i], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NC*NI-1:0] pat;
    #1;
    // Reset: every channel routes input 0.
    IN = 64'h0000_0000_0001_0001;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1);
    check_val("rst_O",      64'(O),          64'h3);
    check_val("rst_active", 64'(active_sel), 64'h0);
    check_val("rst_ready",  64'(cfg_ready),  64'h1);

    // Load F5A3, backpressure while FULL, then commit.
    load_bits(16'hF5A3, 16, 0);
    check_val("full_after16",  64'(cfg_full),  64'h1);
    check_val("ready_after16", 64'(cfg_ready), 64'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'(i % 2), 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("commit_active", 64'(active_sel),  64'hF5A3);
    check_val("commit_done",   64'(commit_done), 64'h1);
    idle(1);
    check_val("done_pulse", 64'(commit_done), 64'h0);
    check_val("ready_post", 64'(cfg_ready),   64'h1);
    pat = '0;
    pat[3] = 1'b1; pat[26] = 1'b1; pat[37] = 1'b1; pat[63] = 1'b1;
    IN = pat;
    #1 check_val("route_hot",  64'(O), 64'hF);
    IN = ~pat;
    #1 check_val("route_cold", 64'(O), 64'h0);
    for (int i = 0; i < 4; i++) begin
      IN = {$urandom(), $urandom()};
      idle(1);
    end

    // Early commit sets sticky error without disturbing the load.
    load_bits(16'h1234, 7, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("early_err",    64'(cfg_err),    64'h1);
    check_val("early_active", 64'(active_sel), 64'hF5A3);
    load_bits(16'h1234, 9, 7);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("late_active", 64'(active_sel), 64'h1234);
    check_val("err_sticky",  64'(cfg_err),    64'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("err_clr", 64'(cfg_err), 64'h0);

    // Abort with a simultaneous transfer drops the bit; full reload works.
    load_bits(16'hAAAA, 10, 0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    load_bits(16'h5C3E, 16, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("reload_active", 64'(active_sel), 64'h5C3E);

    // Abort beats commit in FULL.
    load_bits(16'h0F0F, 16, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_val("abort_pri_err",   64'(cfg_err),   64'h0);
    check_val("abort_pri_ready", 64'(cfg_ready), 64'h1);

    // Commit with the last bit: bit taken, error flagged, no commit.
    load_bits(16'h9999, 15, 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("last_full",   64'(cfg_full),   64'h1);
    check_val("last_err",    64'(cfg_err),    64'h1);
    check_val("last_active", 64'(active_sel), 64'h5C3E);
    // Clear and new error coinciding: set wins.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check_val("last_commit", 64'(active_sel), 64'h9999);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    check_val("set_wins", 64'(cfg_err), 64'h1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset mid-load clears the active register too.
    load_bits(16'hF5A3, 16, 0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    load_bits(16'h7777, 10, 0);
    IN = {$urandom(), $urandom()};
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("midrst_active", 64'(active_sel), 64'h0);
    check_val("midrst_O", 64'(O), 64'({IN[48], IN[32], IN[16], IN[0]}));
    idle(2);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
